// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the 5-stage MIPS core.
//   - ALUOp values produced by the decode controller (0 = none)
//   - jump_pre_Op encodings
//   - bit positions inside the 9-bit control bundle
//   - REG_RA, the link register index used by jal/jalr
package mips_pkg;

  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_NOR  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_BEQ  = 4'd10;
  localparam logic [3:0] ALU_BNE  = 4'd11;

  localparam logic [1:0] JP_NONE   = 2'd0;
  localparam logic [1:0] JP_JR     = 2'd1;  // jr / jalr
  localparam logic [1:0] JP_BRANCH = 2'd2;  // beq / bne
  localparam logic [1:0] JP_J      = 2'd3;  // j / jal

  localparam int unsigned CTRL_W = 9;

  // Control bundle bit positions (MSB first in the packed vector).
  localparam int unsigned CTRL_M_RT_RD       = 8;  // 1: dest = rd
  localparam int unsigned CTRL_M_ALU_PC8     = 7;
  localparam int unsigned CTRL_MEM_WE        = 6;
  localparam int unsigned CTRL_M_RT2_IMM     = 5;  // 1: ALU operand B = imm (rt unused)
  localparam int unsigned CTRL_REG_WE        = 4;
  localparam int unsigned CTRL_M_DTLH_ALUPC8 = 3;  // 0: writeback from memory (load)
  localparam int unsigned CTRL_M_R_31        = 2;  // 1: dest = $ra
  localparam int unsigned CTRL_M_DT_LH       = 1;
  localparam int unsigned CTRL_M_DT_SH       = 0;

  localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/load_use_detector.sv
// load_use_detector: combinational load-use hazard check between the instruction in EX and
// the one in ID.
// Ports:
//   i_ex_valid, i_ex_reg_we, i_ex_from_alu : EX slot status / writeback source
//   i_ex_wr_reg                            : EX destination register
//   i_id_valid, i_id_rs, i_id_rt           : ID instruction and its source indices
//   i_id_uses_rt                           : ID actually reads rt (R-type operand or store data)
//   o_load_use                             : ID must wait one cycle for the load result
module load_use_detector #(
  parameter int unsigned RW = 5
) (
  input  logic          i_ex_valid,
  input  logic          i_ex_reg_we,
  input  logic          i_ex_from_alu,
  input  logic [RW-1:0] i_ex_wr_reg,
  input  logic          i_id_valid,
  input  logic [RW-1:0] i_id_rs,
  input  logic [RW-1:0] i_id_rt,
  input  logic          i_id_uses_rt,
  output logic          o_load_use
);

  logic w_ex_is_load;
  logic w_match;

  // A load writes a register whose value only arrives from memory; $0 never creates a hazard.
  assign w_ex_is_load = i_ex_valid & i_ex_reg_we & ~i_ex_from_alu & (i_ex_wr_reg != '0);
  assign w_match      = (i_ex_wr_reg == i_id_rs) | ((i_ex_wr_reg == i_id_rt) & i_id_uses_rt);
  assign o_load_use   = w_ex_is_load & i_id_valid & w_match;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection.
// Captures the decode control bundle and ID operands each cycle (1-cycle latency). Priority per
// edge: mem_stall holds everything > ex_flush bubble > load-use bubble > capture.
// A bubble clears valid and all control fields; data registers simply hold.
// Ports: clk/rst (async active-low); id_* inputs from decode; ex_flush / mem_stall from later
// stages; ex_* registered outputs to EX; hazard_stall (comb.) freezes PC and IF/ID;
// bubble_cnt / flush_cnt perf counters.
// Build option: define ID_EX_PERF_EN to implement the perf counters (otherwise tied to 0).
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned RW    = 5,
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [3:0]        id_ALUOp,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [1:0]        id_jump_pre_Op,
  input  logic [DW-1:0]     id_pc8,
  input  logic [DW-1:0]     id_rs_data,
  input  logic [DW-1:0]     id_rt_data,
  input  logic [DW-1:0]     id_imm,
  input  logic [4:0]        id_shamt,
  input  logic [RW-1:0]     id_rs,
  input  logic [RW-1:0]     id_rt,
  input  logic [RW-1:0]     id_rd,
  input  logic              ex_flush,
  input  logic              mem_stall,
  output logic              ex_valid,
  output logic [3:0]        ex_ALUOp,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [1:0]        ex_jump_pre_Op,
  output logic [DW-1:0]     ex_pc8,
  output logic [DW-1:0]     ex_rs_data,
  output logic [DW-1:0]     ex_rt_data,
  output logic [DW-1:0]     ex_imm,
  output logic [4:0]        ex_shamt,
  output logic [RW-1:0]     ex_rs,
  output logic [RW-1:0]     ex_rt,
  output logic [RW-1:0]     ex_wr_reg,
  output logic              hazard_stall,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              r_valid;
  logic [3:0]        r_alu_op;
  logic [CTRL_W-1:0] r_ctrl;
  logic [1:0]        r_jop;
  logic [DW-1:0]     r_pc8, r_rs_data, r_rt_data, r_imm;
  logic [4:0]        r_shamt;
  logic [RW-1:0]     r_rs, r_rt, r_wr_reg;

  logic              w_load_use;
  logic              w_id_uses_rt;
  logic [RW-1:0]     w_id_wr_reg;

  // rt is a real source unless the immediate replaces it; stores still read rt as data.
  assign w_id_uses_rt = ~id_ctrl[CTRL_M_RT2_IMM] | id_ctrl[CTRL_MEM_WE];

  always_comb begin
    w_id_wr_reg = id_rt;
    if (id_ctrl[CTRL_M_R_31]) begin
      w_id_wr_reg = RW'(REG_RA);
    end else if (id_ctrl[CTRL_M_RT_RD]) begin
      w_id_wr_reg = id_rd;
    end
  end

  load_use_detector #(
    .RW (RW)
  ) u_load_use_detector (
    .i_ex_valid    (r_valid),
    .i_ex_reg_we   (r_ctrl[CTRL_REG_WE]),
    .i_ex_from_alu (r_ctrl[CTRL_M_DTLH_ALUPC8]),
    .i_ex_wr_reg   (r_wr_reg),
    .i_id_valid    (id_valid),
    .i_id_rs       (id_rs),
    .i_id_rt       (id_rt),
    .i_id_uses_rt  (w_id_uses_rt),
    .o_load_use    (w_load_use)
  );

  // While mem_stall the whole stage is frozen, so requesting a stall upstream is redundant.
  assign hazard_stall = w_load_use & ~ex_flush & ~mem_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid   <= 1'b0;
      r_alu_op  <= '0;
      r_ctrl    <= '0;
      r_jop     <= '0;
      r_pc8     <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_shamt   <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_wr_reg  <= '0;
    end else if (!mem_stall) begin
      if (ex_flush || w_load_use) begin
        r_valid  <= 1'b0;
        r_alu_op <= '0;
        r_ctrl   <= '0;
        r_jop    <= '0;
      end else begin
        r_valid   <= id_valid;
        r_alu_op  <= id_valid ? id_ALUOp : '0;
        r_ctrl    <= id_valid ? id_ctrl : '0;
        r_jop     <= id_valid ? id_jump_pre_Op : '0;
        r_pc8     <= id_pc8;
        r_rs_data <= id_rs_data;
        r_rt_data <= id_rt_data;
        r_imm     <= id_imm;
        r_shamt   <= id_shamt;
        r_rs      <= id_rs;
        r_rt      <= id_rt;
        r_wr_reg  <= w_id_wr_reg;
      end
    end
  end

`ifdef ID_EX_PERF_EN
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else if (!mem_stall) begin
      if (ex_flush) begin
        if (id_valid) begin
          r_flush_cnt <= r_flush_cnt + 1'b1;
        end
      end else if (w_load_use) begin
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
    end
  end

  assign bubble_cnt = r_bubble_cnt;
  assign flush_cnt  = r_flush_cnt;
`else
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif

  assign ex_valid       = r_valid;
  assign ex_ALUOp       = r_alu_op;
  assign ex_ctrl        = r_ctrl;
  assign ex_jump_pre_Op = r_jop;
  assign ex_pc8         = r_pc8;
  assign ex_rs_data     = r_rs_data;
  assign ex_rt_data     = r_rt_data;
  assign ex_imm         = r_imm;
  assign ex_shamt       = r_shamt;
  assign ex_rs          = r_rs;
  assign ex_rt          = r_rt;
  assign ex_wr_reg      = r_wr_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed-vector bench for id_ex_stage with hand-computed expectations.
module tb_id_ex_stage;

  localparam int unsigned DW    = 32;
  localparam int unsigned RW    = 5;
  localparam int unsigned CNT_W = 32;

  // Control bundles: {Rt_Rd,ALU_PC8,mem_we,Rt2_imm,reg_we,dtlh_ALUPC8,R_31,dt_lh,dt_sh}
  localparam logic [8:0] C_LW   = 9'h030;  // reg_we, imm, data from memory
  localparam logic [8:0] C_ADD  = 9'h118;  // Rt_Rd, reg_we, ALU result
  localparam logic [8:0] C_ADDI = 9'h038;  // imm, reg_we, ALU result
  localparam logic [8:0] C_SW   = 9'h060;  // mem_we, imm
  localparam logic [8:0] C_JAL  = 9'h09C;  // ALU_PC8, reg_we, ALU result, R_31

`ifdef ID_EX_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [3:0]       id_ALUOp;
  logic [8:0]       id_ctrl;
  logic [1:0]       id_jump_pre_Op;
  logic [DW-1:0]    id_pc8, id_rs_data, id_rt_data, id_imm;
  logic [4:0]       id_shamt;
  logic [RW-1:0]    id_rs, id_rt, id_rd;
  logic             ex_flush, mem_stall;
  logic             ex_valid;
  logic [3:0]       ex_ALUOp;
  logic [8:0]       ex_ctrl;
  logic [1:0]       ex_jump_pre_Op;
  logic [DW-1:0]    ex_pc8, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]       ex_shamt;
  logic [RW-1:0]    ex_rs, ex_rt, ex_wr_reg;
  logic             hazard_stall;
  logic [CNT_W-1:0] bubble_cnt, flush_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(
    .DW    (DW),
    .RW    (RW),
    .CNT_W (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_ALUOp       (id_ALUOp),
    .id_ctrl        (id_ctrl),
    .id_jump_pre_Op (id_jump_pre_Op),
    .id_pc8         (id_pc8),
    .id_rs_data     (id_rs_data),
    .id_rt_data     (id_rt_data),
    .id_imm         (id_imm),
    .id_shamt       (id_shamt),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_rd          (id_rd),
    .ex_flush       (ex_flush),
    .mem_stall      (mem_stall),
    .ex_valid       (ex_valid),
    .ex_ALUOp       (ex_ALUOp),
    .ex_ctrl        (ex_ctrl),
    .ex_jump_pre_Op (ex_jump_pre_Op),
    .ex_pc8         (ex_pc8),
    .ex_rs_data     (ex_rs_data),
    .ex_rt_data     (ex_rt_data),
    .ex_imm         (ex_imm),
    .ex_shamt       (ex_shamt),
    .ex_rs          (ex_rs),
    .ex_rt          (ex_rt),
    .ex_wr_reg      (ex_wr_reg),
    .hazard_stall   (hazard_stall),
    .bubble_cnt     (bubble_cnt),
    .flush_cnt      (flush_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Present an instruction in ID, then let combinational outputs settle.
  task automatic drive_id(input logic v, input logic [3:0] op, input logic [8:0] ctrl,
                          input logic [1:0] jop, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] imm, input logic [31:0] pc8);
    id_valid       = v;
    id_ALUOp       = op;
    id_ctrl        = ctrl;
    id_jump_pre_Op = jop;
    id_rs          = rs;
    id_rt          = rt;
    id_rd          = rd;
    id_imm         = imm;
    id_pc8         = pc8;
    id_rs_data     = 32'h1000 + 32'(rs);
    id_rt_data     = 32'h2000 + 32'(rt);
    id_shamt       = 5'd0;
    #1;
  endtask

  // Advance one rising edge and sample 1 time unit after it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    ex_flush = 1'b0;
    mem_stall = 1'b0;
    drive_id(1'b0, 4'd0, 9'h0, 2'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    tick;
    check_eq("rst_valid", 32'(ex_valid), 32'd0);
    check_eq("rst_ctrl", 32'(ex_ctrl), 32'd0);
    check_eq("rst_wr_reg", 32'(ex_wr_reg), 32'd0);
    check_eq("rst_bubble_cnt", bubble_cnt, 32'd0);
    rst = 1'b1;

    // lw $8,0($2) enters EX
    drive_id(1'b1, 4'd1, C_LW, 2'd0, 5'd2, 5'd8, 5'd0, 32'd0, 32'h108);
    tick;
    check_eq("lw_valid", 32'(ex_valid), 32'd1);
    check_eq("lw_ctrl", 32'(ex_ctrl), 32'(C_LW));
    check_eq("lw_wr_reg", 32'(ex_wr_reg), 32'd8);
    check_eq("lw_rs", 32'(ex_rs), 32'd2);
    check_eq("lw_rs_data", ex_rs_data, 32'h1002);

    // add $9,$8,$3: one stall, one bubble, then add proceeds
    drive_id(1'b1, 4'd1, C_ADD, 2'd0, 5'd8, 5'd3, 5'd9, 32'd0, 32'h10C);
    check_eq("add_stall", 32'(hazard_stall), 32'd1);
    tick;
    check_eq("bubble_valid", 32'(ex_valid), 32'd0);
    check_eq("bubble_ctrl", 32'(ex_ctrl), 32'd0);
    check_eq("bubble_aluop", 32'(ex_ALUOp), 32'd0);
    check_eq("after_bubble_stall", 32'(hazard_stall), 32'd0);
    tick;
    check_eq("add_valid", 32'(ex_valid), 32'd1);
    check_eq("add_ctrl", 32'(ex_ctrl), 32'(C_ADD));
    check_eq("add_wr_reg", 32'(ex_wr_reg), 32'd9);
    check_eq("bubble_cnt_1", bubble_cnt, PERF ? 32'd1 : 32'd0);

    // lw $8 again, then variants of the dependent instruction in ID
    drive_id(1'b1, 4'd1, C_LW, 2'd0, 5'd2, 5'd8, 5'd0, 32'd0, 32'h110);
    tick;
    drive_id(1'b1, 4'd1, C_ADDI, 2'd0, 5'd8, 5'd9, 5'd0, 32'd4, 32'h114);
    check_eq("addi_rs_stall", 32'(hazard_stall), 32'd1);
    drive_id(1'b1, 4'd1, C_ADDI, 2'd0, 5'd2, 5'd8, 5'd0, 32'd4, 32'h114);
    check_eq("addi_rt_imm_nostall", 32'(hazard_stall), 32'd0);
    drive_id(1'b1, 4'd1, C_SW, 2'd0, 5'd2, 5'd8, 5'd0, 32'd0, 32'h114);
    check_eq("sw_data_stall", 32'(hazard_stall), 32'd1);
    drive_id(1'b0, 4'd1, C_ADD, 2'd0, 5'd8, 5'd8, 5'd9, 32'd0, 32'h114);
    check_eq("id_invalid_nostall", 32'(hazard_stall), 32'd0);

    // lw $0 never causes a hazard
    drive_id(1'b1, 4'd1, C_LW, 2'd0, 5'd2, 5'd0, 5'd0, 32'd0, 32'h118);
    tick;
    drive_id(1'b1, 4'd1, C_ADD, 2'd0, 5'd0, 5'd0, 5'd9, 32'd0, 32'h11C);
    check_eq("lw_r0_nostall", 32'(hazard_stall), 32'd0);

    // Flush kills a valid jal
    drive_id(1'b1, 4'd0, C_JAL, 2'd3, 5'd0, 5'd0, 5'd0, 32'd0, 32'h120);
    ex_flush = 1'b1;
    #1;
    tick;
    check_eq("flush_valid", 32'(ex_valid), 32'd0);
    check_eq("flush_ctrl", 32'(ex_ctrl), 32'd0);
    check_eq("flush_jop", 32'(ex_jump_pre_Op), 32'd0);
    check_eq("flush_cnt_1", flush_cnt, PERF ? 32'd1 : 32'd0);

    // Flush and load-use in the same cycle: flush wins, no stall
    ex_flush = 1'b0;
    drive_id(1'b1, 4'd1, C_LW, 2'd0, 5'd2, 5'd8, 5'd0, 32'd0, 32'h124);
    tick;
    drive_id(1'b1, 4'd1, C_ADD, 2'd0, 5'd8, 5'd3, 5'd9, 32'd0, 32'h128);
    ex_flush = 1'b1;
    #1;
    check_eq("flush_lu_stall", 32'(hazard_stall), 32'd0);
    tick;
    ex_flush = 1'b0;
    check_eq("flush_lu_valid", 32'(ex_valid), 32'd0);
    check_eq("flush_cnt_2", flush_cnt, PERF ? 32'd2 : 32'd0);
    check_eq("bubble_cnt_keep", bubble_cnt, PERF ? 32'd1 : 32'd0);

    // mem_stall for three edges with a load-use pending
    drive_id(1'b1, 4'd1, C_LW, 2'd0, 5'd2, 5'd8, 5'd0, 32'd0, 32'h12C);
    tick;
    drive_id(1'b1, 4'd1, C_ADD, 2'd0, 5'd8, 5'd3, 5'd9, 32'd0, 32'h130);
    mem_stall = 1'b1;
    #1;
    check_eq("mstall_hazard", 32'(hazard_stall), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
    end
    check_eq("mstall_valid", 32'(ex_valid), 32'd1);
    check_eq("mstall_ctrl", 32'(ex_ctrl), 32'(C_LW));
    check_eq("mstall_wr_reg", 32'(ex_wr_reg), 32'd8);
    check_eq("mstall_pc8", ex_pc8, 32'h12C);
    check_eq("mstall_bubble_cnt", bubble_cnt, PERF ? 32'd1 : 32'd0);
    check_eq("mstall_flush_cnt", flush_cnt, PERF ? 32'd2 : 32'd0);
    mem_stall = 1'b0;
    #1;
    check_eq("post_mstall_hazard", 32'(hazard_stall), 32'd1);

    // Reset asserted mid-stall clears state immediately
    rst = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(ex_valid), 32'd0);
    check_eq("mid_rst_ctrl", 32'(ex_ctrl), 32'd0);
    check_eq("mid_rst_wr_reg", 32'(ex_wr_reg), 32'd0);
    check_eq("mid_rst_stall", 32'(hazard_stall), 32'd0);
    check_eq("mid_rst_bubble_cnt", bubble_cnt, 32'd0);
    tick;
    rst = 1'b1;

    // jalr $4 (rd=5 but R_31 forces $ra)
    drive_id(1'b1, 4'd0, C_JAL, 2'd1, 5'd4, 5'd0, 5'd5, 32'd0, 32'h200);
    tick;
    check_eq("jalr_wr_reg", 32'(ex_wr_reg), 32'd31);
    check_eq("jalr_jop", 32'(ex_jump_pre_Op), 32'd1);
    check_eq("jalr_pc8", ex_pc8, 32'h200);

    // Invalid ID instruction captures as a NOP
    drive_id(1'b0, 4'd1, C_ADD, 2'd2, 5'd1, 5'd2, 5'd3, 32'd0, 32'h204);
    tick;
    check_eq("invalid_valid", 32'(ex_valid), 32'd0);
    check_eq("invalid_ctrl", 32'(ex_ctrl), 32'd0);
    check_eq("invalid_aluop", 32'(ex_ALUOp), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
